// File: rtl/uw_sync_rot.sv
// Frameset buffer and unique-word synchronizer: stores a frameset of soft symbols, finds the sync word
// offset/phase in the first frame, then replays pairs phase-corrected. Optional status: UW_SYNC_ROT_STATUS_EN.
module uw_sync_rot #(
    parameter int         BYTES_PER_FRAME = 80,
    parameter int         NUM_FRAMES      = 32,
    parameter logic [7:0] SYNC_WORD       = 8'h27,
    parameter int         MIN_SCORE       = 7
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic [7:0] soft_inp,
    input  logic       valid_in,
    output logic       ready_in,
    input  logic       ready_tx,
    output logic       valid_out,
    output logic [7:0] soft_out_0,
    output logic [7:0] soft_out_1,
    output logic       new_frameset
`ifdef UW_SYNC_ROT_STATUS_EN
    ,
    output logic                               sync_locked,
    output logic [1:0]                         sync_rot,
    output logic [$clog2(BYTES_PER_FRAME)-1:0] sync_offset
`endif
);

    localparam int FRAMESET = BYTES_PER_FRAME * NUM_FRAMES;
    localparam int HALF     = FRAMESET / 2;
    localparam int CW       = $clog2(FRAMESET + 1);
    localparam int AW       = $clog2(HALF);
    localparam int OW       = $clog2(BYTES_PER_FRAME);

    // state    | meaning
    // FILL     | accepting symbols, streaming sync search
    // PREFETCH | first pair read issued
    // OUTPUT   | presenting rotated pairs downstream
    typedef enum logic [1:0] {FILL, PREFETCH, OUTPUT} state_t;

    state_t        state;
    logic [7:0]    mem_even [HALF];
    logic [7:0]    mem_odd  [HALF];
    logic [CW-1:0] cnt;
    logic [7:0]    sh [7];
    logic [3:0]    best_score;
    logic [OW-1:0] best_off;
    logic [1:0]    best_rot;
    logic [OW-1:0] off_sel;
    logic [1:0]    rot_sel;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   pairs_left;
    logic [7:0]    rd_a, rd_b;

    logic          accept;
    logic          search_hit;
    logic [7:0]    hard;
    logic [3:0]    win_score;
    logic [1:0]    win_rot;
    logic [OW-1:0] win_off;
    logic          locked;
    logic [AW-1:0] first_addr;

    function automatic logic [3:0] rot_score(input logic [7:0] h, input logic [1:0] r);
        logic [3:0] s;
        logic       ha, hb, x, y;
        s = '0;
        for (int j = 0; j < 4; j++) begin
            ha = h[7-2*j];
            hb = h[6-2*j];
            case (r)
                2'd0:    begin x = ha;  y = hb;  end
                2'd1:    begin x = ~hb; y = ha;  end
                2'd2:    begin x = ~ha; y = ~hb; end
                default: begin x = hb;  y = ~ha; end
            endcase
            s = s + {3'b000, x ~^ SYNC_WORD[7-2*j]} + {3'b000, y ~^ SYNC_WORD[6-2*j]};
        end
        return s;
    endfunction

    assign accept     = (state == FILL) && valid_in;
    // the window ends with the symbol being accepted this cycle, so it starts at cnt-7
    assign search_hit = (cnt >= CW'(7)) && cnt[0] && (cnt < CW'(BYTES_PER_FRAME + 7));
    assign win_off    = OW'(cnt - CW'(7));
    assign locked     = best_score >= 4'(MIN_SCORE);
    assign first_addr = AW'(off_sel >> 1);

    always_comb begin
        logic [3:0] sc;
        for (int i = 0; i < 7; i++) hard[7-i] = ~sh[i][7];
        hard[0]   = ~soft_inp[7];
        win_score = '0;
        win_rot   = '0;
        for (int r = 0; r < 4; r++) begin
            sc = rot_score(hard, 2'(r));
            if (sc > win_score) begin
                win_score = sc;
                win_rot   = 2'(r);
            end
        end
    end

    always_comb begin
        soft_out_0 = rd_a;
        soft_out_1 = rd_b;
        case (rot_sel)
            2'd0:    begin soft_out_0 = rd_a;  soft_out_1 = rd_b;  end
            2'd1:    begin soft_out_0 = ~rd_b; soft_out_1 = rd_a;  end
            2'd2:    begin soft_out_0 = ~rd_a; soft_out_1 = ~rd_b; end
            default: begin soft_out_0 = rd_b;  soft_out_1 = ~rd_a; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (cnt[0]) mem_odd[AW'(cnt >> 1)]  <= soft_inp;
            else        mem_even[AW'(cnt >> 1)] <= soft_inp;
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state        <= FILL;
            ready_in     <= 1'b1;
            valid_out    <= 1'b0;
            new_frameset <= 1'b0;
            cnt          <= '0;
            for (int i = 0; i < 7; i++) sh[i] <= '0;
            best_score   <= '0;
            best_off     <= '0;
            best_rot     <= '0;
            off_sel      <= '0;
            rot_sel      <= '0;
            rd_addr      <= '0;
            pairs_left   <= '0;
            rd_a         <= '0;
            rd_b         <= '0;
`ifdef UW_SYNC_ROT_STATUS_EN
            sync_locked  <= 1'b0;
            sync_rot     <= '0;
            sync_offset  <= '0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (valid_in) begin
                        for (int i = 0; i < 6; i++) sh[i] <= sh[i+1];
                        sh[6] <= soft_inp;
                        cnt   <= cnt + CW'(1);
                        if (search_hit && (win_score > best_score)) begin
                            best_score <= win_score;
                            best_off   <= win_off;
                            best_rot   <= win_rot;
                        end
                        // last symbol can never be inside a search window, so best_* is final here
                        if (cnt == CW'(FRAMESET - 1)) begin
                            state    <= PREFETCH;
                            ready_in <= 1'b0;
                            off_sel  <= locked ? best_off : '0;
                            rot_sel  <= locked ? best_rot : 2'd0;
`ifdef UW_SYNC_ROT_STATUS_EN
                            sync_locked <= locked;
                            sync_rot    <= locked ? best_rot : 2'd0;
                            sync_offset <= locked ? best_off : '0;
`endif
                        end
                    end
                end
                PREFETCH: begin
                    rd_a         <= mem_even[first_addr];
                    rd_b         <= mem_odd[first_addr];
                    rd_addr      <= first_addr + AW'(1);
                    pairs_left   <= (AW+1)'(HALF) - {1'b0, first_addr};
                    valid_out    <= 1'b1;
                    new_frameset <= 1'b1;
                    state        <= OUTPUT;
                end
                OUTPUT: begin
                    if (ready_tx) begin
                        new_frameset <= 1'b0;
                        if (pairs_left == (AW+1)'(1)) begin
                            valid_out  <= 1'b0;
                            ready_in   <= 1'b1;
                            state      <= FILL;
                            cnt        <= '0;
                            best_score <= '0;
                            best_off   <= '0;
                            best_rot   <= '0;
                            for (int i = 0; i < 7; i++) sh[i] <= '0;
                        end else begin
                            rd_a       <= mem_even[rd_addr];
                            rd_b       <= mem_odd[rd_addr];
                            rd_addr    <= rd_addr + AW'(1);
                            pairs_left <= pairs_left - (AW+1)'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_uw_sync_rot.sv
// Randomized bench for uw_sync_rot: frameset-level reference model of the sync search and pair replay.
module tb_uw_sync_rot;

    localparam int BPF = 80;
    localparam int FS  = 2560;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [7:0] soft_inp;
    logic       valid_in;
    logic       ready_in;
    logic       ready_tx;
    logic       valid_out;
    logic [7:0] soft_out_0, soft_out_1;
    logic       new_frameset;
`ifdef UW_SYNC_ROT_STATUS_EN
    logic       sync_locked;
    logic [1:0] sync_rot;
    logic [6:0] sync_offset;
`endif

    uw_sync_rot dut (
        .clk(clk), .rst_in(rst_in), .soft_inp(soft_inp), .valid_in(valid_in),
        .ready_in(ready_in), .ready_tx(ready_tx), .valid_out(valid_out),
        .soft_out_0(soft_out_0), .soft_out_1(soft_out_1), .new_frameset(new_frameset)
`ifdef UW_SYNC_ROT_STATUS_EN
        , .sync_locked(sync_locked), .sync_rot(sync_rot), .sync_offset(sync_offset)
`endif
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] syms [FS];
    logic [7:0] sync_w = 8'h27;
    int         m_off, m_rot, m_locked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void rotp(input logic [7:0] a, input logic [7:0] b, input int r,
                                 output logic [7:0] x, output logic [7:0] y);
        case (r)
            0:       begin x = a;  y = b;  end
            1:       begin x = ~b; y = a;  end
            2:       begin x = ~a; y = ~b; end
            default: begin x = b;  y = ~a; end
        endcase
    endfunction

    // offset < 0: no sync word; tx: rotation applied to every pair before transmission
    task automatic build(input int offset, input int tx, input bit neg_only);
        logic [7:0] x, y;
        for (int i = 0; i < FS; i++) syms[i] = neg_only ? (8'h80 | 8'($urandom)) : 8'($urandom);
        if (offset >= 0)
            for (int f = 0; f < FS / BPF; f++)
                for (int k = 0; k < 8; k++)
                    syms[f*BPF + offset + k] = sync_w[7-k] ? 8'h7F : 8'h80;
        for (int p = 0; p < FS; p += 2) begin
            rotp(syms[p], syms[p+1], tx, x, y);
            syms[p] = x;
            syms[p+1] = y;
        end
    endtask

    task automatic model();
        int best, sc;
        logic [7:0] x, y;
        best = 0; m_off = 0; m_rot = 0;
        for (int s = 0; s < BPF; s += 2)
            for (int r = 0; r < 4; r++) begin
                sc = 0;
                for (int j = 0; j < 4; j++) begin
                    rotp(syms[s+2*j], syms[s+2*j+1], r, x, y);
                    sc += int'(~x[7] == sync_w[7-2*j]) + int'(~y[7] == sync_w[6-2*j]);
                end
                if (sc > best) begin best = sc; m_off = s; m_rot = r; end
            end
        m_locked = (best >= 7) ? 1 : 0;
        if (m_locked == 0) begin m_off = 0; m_rot = 0; end
    endtask

    task automatic feed();
        int rdy_err = 0;
        for (int i = 0; i < FS; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                valid_in = 1'b0;
                soft_inp = 8'($urandom);
            end
            @(negedge clk);
            if (ready_in !== 1'b1) rdy_err++;
            valid_in = 1'b1;
            soft_inp = syms[i];
        end
        @(negedge clk);
        valid_in = 1'b0;
        chk("ready_in_during_fill", rdy_err, 0);
        chk("ready_in_drop", ready_in, 1'b0);
`ifdef UW_SYNC_ROT_STATUS_EN
        chk("sync_locked", sync_locked, m_locked);
        chk("sync_rot", sync_rot, m_rot);
        chk("sync_offset", sync_offset, m_off);
`endif
    endtask

    task automatic drain(input int pct, input int stop_after);
        int npairs, k, cycles, hold_err, nf_err, bubble_err;
        bit rt, prev_hold;
        logic [7:0] p0, p1, x, y;
        logic pnf;
        npairs = (FS - m_off) / 2;
        k = 0; cycles = 0; hold_err = 0; nf_err = 0; bubble_err = 0; prev_hold = 0;
        p0 = '0; p1 = '0; pnf = 1'b0;
        while (k < npairs && k < stop_after && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (prev_hold && (valid_out !== 1'b1 || soft_out_0 !== p0 || soft_out_1 !== p1 || new_frameset !== pnf))
                hold_err++;
            if (k > 0 && valid_out !== 1'b1) bubble_err++;
            rt = ($urandom_range(0, 99) < pct);
            ready_tx = rt;
            valid_in = 1'($urandom);
            soft_inp = 8'($urandom);
            if (valid_out && rt) begin
                rotp(syms[m_off+2*k], syms[m_off+2*k+1], m_rot, x, y);
                chk($sformatf("out0[%0d]", k), soft_out_0, x);
                chk($sformatf("out1[%0d]", k), soft_out_1, y);
                if (new_frameset !== (k == 0)) nf_err++;
                k++;
            end
            prev_hold = valid_out && !rt;
            p0 = soft_out_0; p1 = soft_out_1; pnf = new_frameset;
        end
        chk("hold_stable", hold_err, 0);
        chk("new_frameset_pair0_only", nf_err, 0);
        chk("no_bubble", bubble_err, 0);
        if (stop_after >= npairs) begin
            chk("pair_count", k, npairs);
            @(negedge clk);
            valid_in = 1'b0;
            chk("valid_out_after_last", valid_out, 1'b0);
            chk("ready_in_after_last", ready_in, 1'b1);
        end
    endtask

    task automatic run(input int offset, input int tx, input bit neg_only, input int pct);
        build(offset, tx, neg_only);
        model();
        feed();
        drain(pct, FS);
    endtask

    initial begin
        rst_in = 1'b1; valid_in = 1'b0; ready_tx = 1'b0; soft_inp = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready_in", ready_in, 1'b1);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_soft_out_0", soft_out_0, 8'h00);
        chk("rst_soft_out_1", soft_out_1, 8'h00);
        chk("rst_new_frameset", new_frameset, 1'b0);
        rst_in = 1'b0;
        @(negedge clk);

        run(0, 0, 1'b0, 100);
        run(0, 3, 1'b0, 100);
        run(10, 0, 1'b0, 100);
        run(0, 0, 1'b0, 50);
        run(-1, 0, 1'b1, 70);

        for (int n = 0; n < 2; n++)
            run(2 * $urandom_range(0, 36), $urandom_range(0, 3), 1'b0, 80);
        build(2 * $urandom_range(0, 36), $urandom_range(0, 3), 1'b0);
        model();
        feed();
        drain(80, 300);
        rst_in = 1'b1;
        #1;
        chk("midrst_valid_out", valid_out, 1'b0);
        chk("midrst_ready_in", ready_in, 1'b1);
        chk("midrst_new_frameset", new_frameset, 1'b0);
        chk("midrst_soft_out_0", soft_out_0, 8'h00);
`ifdef UW_SYNC_ROT_STATUS_EN
        chk("midrst_sync_locked", sync_locked, 1'b0);
`endif
        @(negedge clk);
        rst_in = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        run(6, 2, 1'b0, 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
